di_bus_master: RTL and testbench
================================

// Module: di_bus_master
// PURPOSE
//  Initiator side of the DI terminal bus. Accepts one command at a time (read or write,
//  terminal, register address, byte length) and sequences di_write_mode/di_write or
//  di_read_mode/di_read_req/di_read against a terminal responder, honouring di_read_rdy /
//  di_write_rdy. Returns read words and a per-transfer status. Drives FPGA-internal
//  terminals (e.g. the FPGA terminal) from on-chip sequencers and the testbench host model.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max consecutive cycles waiting on a rdy before abort (DI_TIMEOUT_EN only)
// PORTS
//  ifclk               in   1   clock, 48MHz; all logic on rising edge
//  reset               in   1   async active-high reset
//  cmd_valid           in   1   command present
//  cmd_ready           out  1   high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_write           in   1   1=write transfer, 0=read transfer
//  cmd_term            in   16  terminal address
//  cmd_addr            in   32  register address
//  cmd_len             in   32  length in bytes; words = cmd_len[31:2], bits[1:0] ignored
//  wdata / wdata_valid in 32/1  write word stream
//  wdata_ready         out  1   word consumed when wdata_valid & wdata_ready
//  rdata               out  32  read word (= di_reg_datao)
//  rdata_valid         out  1   read word available
//  rdata_ready         in   1   consumer accepts read word
//  rsp_valid           out  1   one-cycle pulse at end of transfer
//  rsp_status          out  16  captured di_transfer_status (16'hFFFE on timeout)
//  rsp_timeout         out  1   valid with rsp_valid; transfer aborted by timeout
//  busy                out  1   state != IDLE
//  di_term_addr/di_reg_addr/di_len  out 16/32/32  registered from cmd at accept, held to end
//  di_read_mode/di_read_req/di_read/di_write_mode/di_write  out 1  bus strobes
//  di_reg_datai        out  32  write data
//  di_read_rdy/di_write_rdy  in 1;  di_reg_datao in 32;  di_transfer_status in 16
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; mid-transfer reset drops all modes/strobes at once, no rsp.
//  States IDLE, WR, RD_REQ, RD_WAIT, DONE. word_cnt (30b) loads cmd_len[31:2] at accept.
//  IDLE: on accept register term/addr/len; words==0 -> DONE; else write -> WR, read -> RD_REQ.
//  WR: di_write_mode=1. wdata_ready = di_write_rdy. On wdata_valid & di_write_rdy:
//   di_write=1 one cycle (combinational), di_reg_datai=wdata, word_cnt--; last word -> DONE.
//   Back-to-back words allowed every cycle.
//  RD_REQ: di_read_mode=1, di_read_req=1 for exactly one cycle -> RD_WAIT.
//  RD_WAIT: di_read_mode=1. rdata_valid = di_read_rdy; rdata = di_reg_datao.
//   di_read = di_read_rdy & rdata_ready (one cycle); word_cnt--; more words -> RD_REQ, else DONE.
//  DONE: modes low, rsp_valid=1 one cycle, rsp_status <= di_transfer_status sampled this
//   cycle, rsp_timeout=0 -> IDLE. New command accepted earliest the cycle after DONE.
//  di_*_mode never both high. rsp_status/rsp_timeout hold until next rsp_valid.
//  Write ending with wdata_valid low simply stalls in WR; no underrun error.
// CONFIGURATION
//  DI_TIMEOUT_EN defined: 32b wait counter clears on any strobe or state change, increments
//   each cycle in WR (di_write_rdy|wdata_valid low blocks) or RD_WAIT (di_read_rdy low);
//   reaching TIMEOUT_CYCLES -> DONE with rsp_status=16'hFFFE, rsp_timeout=1.
//  Undefined: no counter; waits indefinitely; rsp_timeout tied 0.
// TESTING
//  1 Write term=1,addr=0x10,len=12, rdy=1, wdata always valid -> 3 consecutive di_write
//    pulses, di_write_mode high 3 cycles, rsp_valid with rsp_status=0.
//  2 Read len=8, responder di_read_rdy 3 cycles after each di_read_req -> 2 req pulses,
//    2 di_read pulses, rdata matches di_reg_datao, rsp_status=0.
//  3 len=0 and len=3 -> no strobes, no mode, rsp_valid 1 cycle after accept.
//  4 Write len=16 with di_write_rdy toggling 1/0 -> exactly 4 di_write, all only when rdy=1.
//  5 DI_TIMEOUT_EN, TIMEOUT_CYCLES=16, read with di_read_rdy stuck 0 -> abort after 16
//    cycles, rsp_status=16'hFFFE, rsp_timeout=1, modes low.
//  6 Assert reset mid-read (word 2 of 4) -> all outputs 0 next edge, IDLE, new cmd accepted.

Source files
------------

// File: rtl/di_bus_master.sv
// DI terminal bus initiator: sequences one read or write command at a time against a responder.
// Defining DI_TIMEOUT_EN adds a wait-timeout abort after TIMEOUT_CYCLES stalled cycles.
module di_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_term,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_len,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_status,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] di_term_addr,
  output logic [31:0] di_reg_addr,
  output logic [31:0] di_len,
  output logic        di_read_mode,
  output logic        di_read_req,
  output logic        di_read,
  output logic        di_write_mode,
  output logic        di_write,
  output logic [31:0] di_reg_datai,
  input  logic        di_read_rdy,
  input  logic        di_write_rdy,
  input  logic [31:0] di_reg_datao,
  input  logic [15:0] di_transfer_status,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [29:0] word_cnt;
  logic [15:0] rsp_status_q;
  logic [15:0] done_status;
  logic        last_word;
  logic        accept;
  logic        abort;

  // All handshakes are valid/ready: a transfer happens in a cycle where both are high,
  // valid never waits on ready, and ready may depend combinationally on bus rdy inputs.
  assign cmd_ready = (state == IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  assign last_word = (word_cnt == 30'd1);
  assign state_dbg = state;

  always_comb begin
    state_nx      = state;
    wdata_ready   = 1'b0;
    di_write_mode = 1'b0;
    di_write      = 1'b0;
    di_reg_datai  = 32'd0;
    di_read_mode  = 1'b0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;
    rdata         = 32'd0;
    rdata_valid   = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_len[31:2] == 30'd0) state_nx = DONE;
          else if (cmd_write)         state_nx = WR;
          else                        state_nx = RD_REQ;
        end
      end
      WR: begin
        di_write_mode = 1'b1;
        wdata_ready   = di_write_rdy;
        di_write      = wdata_valid & di_write_rdy;
        di_reg_datai  = wdata;
        if (di_write && last_word) state_nx = DONE;
        else if (abort)            state_nx = DONE;
      end
      RD_REQ: begin
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        state_nx     = RD_WAIT;
      end
      RD_WAIT: begin
        di_read_mode = 1'b1;
        rdata_valid  = di_read_rdy;
        rdata        = di_reg_datao;
        di_read      = di_read_rdy & rdata_ready;
        if (di_read)    state_nx = last_word ? DONE : RD_REQ;
        else if (abort) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status is presented live during DONE and held in a register afterwards.
  assign rsp_status = (state == DONE) ? done_status : rsp_status_q;

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= 30'd0;
      di_term_addr <= 16'd0;
      di_reg_addr  <= 32'd0;
      di_len       <= 32'd0;
      rsp_status_q <= 16'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        word_cnt     <= cmd_len[31:2];
        di_term_addr <= cmd_term;
        di_reg_addr  <= cmd_addr;
        di_len       <= cmd_len;
      end else if (di_write || di_read) begin
        word_cnt <= word_cnt - 30'd1;
      end
      if (state == DONE) rsp_status_q <= done_status;
    end
  end

`ifdef DI_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        to_flag;
  logic        rsp_timeout_q;
  logic        stall;

  // A stalled cycle is one where the current state is waiting on the responder or writer.
  assign stall = ((state == WR) && !(wdata_valid && di_write_rdy)) ||
                 ((state == RD_WAIT) && !di_read_rdy);
  assign abort       = stall && (wait_cnt >= (TIMEOUT_CYCLES - 32'd1));
  assign done_status = to_flag ? 16'hFFFE : di_transfer_status;
  assign rsp_timeout = (state == DONE) ? to_flag : rsp_timeout_q;

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      wait_cnt      <= 32'd0;
      to_flag       <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if ((state_nx != state) || di_write || di_read || di_read_req) wait_cnt <= 32'd0;
      else if (stall)                                             wait_cnt <= wait_cnt + 32'd1;
      if (abort)              to_flag <= 1'b1;
      else if (state == DONE) to_flag <= 1'b0;
      if (state == DONE) rsp_timeout_q <= to_flag;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign abort              = 1'b0;
  assign done_status        = di_transfer_status;
  assign rsp_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_di_bus_master.sv
// Bench for di_bus_master: directed and randomized transfers against a cycle-level responder model.
module tb_di_bus_master;
  localparam int TO = 16;

  logic        ifclk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_term;
  logic [31:0] cmd_addr, cmd_len;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, rdata_ready;
  logic        rsp_valid, rsp_timeout, busy;
  logic [15:0] rsp_status;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr, di_len;
  logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
  logic [31:0] di_reg_datai;
  logic        di_read_rdy, di_write_rdy;
  logic [31:0] di_reg_datao;
  logic [15:0] di_transfer_status;
  logic [2:0]  state_dbg;

  di_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .ifclk(ifclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_term(cmd_term), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout), .busy(busy),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy), .di_reg_datao(di_reg_datao),
    .di_transfer_status(di_transfer_status), .state_dbg(state_dbg)
  );

  // clock / reset
  always #10 ifclk = ~ifclk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'b0;
    cmd_term  = 16'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = $urandom;
    cmd_write = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_cmd(input logic wr, input logic [15:0] t, input logic [31:0] a,
                           input logic [31:0] len, input logic [15:0] st);
    @(negedge ifclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_term = t; cmd_addr = a; cmd_len = len;
    di_transfer_status = st;
    #1;
    chk1("cmd_ready_idle", cmd_ready, 1'b1);
    chk1("busy_idle", busy, 1'b0);
    @(posedge ifclk);
  endtask

  task automatic post_idle(input logic [15:0] t, input logic [15:0] st, input logic to);
    @(negedge ifclk);
    scramble_cmd();
    di_transfer_status = ~st;
    di_read_rdy = 1'b0;
    #1;
    chk1("idle_rsp_valid", rsp_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    chkw("idle_status_hold", 64'(rsp_status), 64'(st));
    chk1("idle_timeout_hold", rsp_timeout, to);
    chk1("idle_modes", di_read_mode | di_write_mode, 1'b0);
    chkw("idle_term_hold", 64'(di_term_addr), 64'(t));
  endtask

  // driver + model: write transfer. rdy_mode 0=always,1=toggle,2=random; vld_mode 0=always,1=random
  task automatic do_write(input logic [15:0] t, input logic [31:0] a, input logic [31:0] len,
                          input int rdy_mode, input int vld_mode, input int exp_mode_cyc);
    int nwords, sent, mode_cyc, cyc;
    logic [15:0] st;
    bit done;
    nwords = int'(len >> 2);
    st = 16'($urandom);
    exp_q.delete();
    for (int i = 0; i < nwords; i++) exp_q.push_back($urandom);
    issue_cmd(1'b1, t, a, len, st);
    sent = 0; mode_cyc = 0; done = 0;
    for (cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge ifclk);
      scramble_cmd();
      case (rdy_mode)
        0:       di_write_rdy = 1'b1;
        1:       di_write_rdy = (cyc % 2 == 1);
        default: di_write_rdy = 1'($urandom_range(0, 1));
      endcase
      wdata_valid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sent < nwords) wdata = exp_q[sent];
      else               wdata = $urandom;
      #1;
      if (cyc == 1) begin
        chkw("wr_term_reg", 64'(di_term_addr), 64'(t));
        chkw("wr_addr_reg", 64'(di_reg_addr), 64'(a));
        chkw("wr_len_reg", 64'(di_len), 64'(len));
      end
      chk1("wr_mode", di_write_mode, sent < nwords);
      chk1("wr_strobe", di_write, (sent < nwords) && wdata_valid && di_write_rdy);
      chk1("wdata_ready", wdata_ready, (sent < nwords) && di_write_rdy);
      chk1("rd_mode_in_wr", di_read_mode | di_read_req | di_read, 1'b0);
      chk1("wr_cmd_ready_busy", cmd_ready, 1'b0);
      chk1("wr_rsp_valid", rsp_valid, sent == nwords);
      if (di_write_mode) mode_cyc++;
      if (di_write) begin
        chkw("wr_datai", 64'(di_reg_datai), 64'(exp_q[sent]));
        sent++;
      end
      if (rsp_valid) begin
        done = 1;
        chkw("wr_rsp_status", 64'(rsp_status), 64'(st));
        chk1("wr_rsp_timeout", rsp_timeout, 1'b0);
        chkw("wr_word_count", 64'(sent), 64'(nwords));
        chkw("wr_term_held", 64'(di_term_addr), 64'(t));
        if (nwords == 0) chkw("zero_len_rsp_cycle", 64'(cyc), 64'(1));
        if (exp_mode_cyc >= 0) chkw("wr_mode_cycles", 64'(mode_cyc), 64'(exp_mode_cyc));
      end
    end
    chk1("wr_rsp_within_budget", done, 1'b1);
    wdata_valid = 1'b0;
    post_idle(t, st, 1'b0);
  endtask

  // driver + model: read transfer with a responder answering lat cycles after each request
  task automatic do_read(input logic [15:0] t, input logic [31:0] a, input logic [31:0] len,
                         input int lat, input int rr_mode, input bit stuck, input int reset_at);
    int nwords, reads, reqs, lat_cnt, cyc;
    logic [15:0] st;
    bit done, pending, aborted, exp_mode, exp_rsp;
    nwords = int'(len >> 2);
    st = 16'($urandom);
    exp_q.delete();
    issue_cmd(1'b0, t, a, len, st);
    reads = 0; reqs = 0; lat_cnt = 0; done = 0; pending = 0; aborted = 0;
    for (cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge ifclk);
      scramble_cmd();
      if (pending && lat_cnt > 0) lat_cnt--;
      if (reset_at >= 0 && reads == reset_at && pending) begin
        reset = 1'b1;
        di_read_rdy = 1'b0;
        #1;
        chkw("rst_mid_ctrl", 64'({cmd_ready, wdata_ready, rdata_valid, rsp_valid, rsp_timeout, busy,
                                  di_read_mode, di_read_req, di_read, di_write_mode, di_write}), 64'(0));
        chkw("rst_mid_regs", 64'({di_term_addr, di_len}), 64'(0));
        chkw("rst_mid_data", 64'({rdata, di_reg_datai}), 64'(0));
        @(posedge ifclk);
        #1;
        chkw("rst_edge_ctrl", 64'({busy, di_read_mode, di_read_req, rsp_valid}), 64'(0));
        chkw("rst_edge_regs", 64'({rsp_status, di_reg_addr}), 64'(0));
        @(negedge ifclk);
        reset = 1'b0;
        #1;
        chk1("rst_release_ready", cmd_ready, 1'b1);
        pending = 0; aborted = 1; done = 1;
        exp_q.delete();
        continue;
      end
      di_read_rdy = pending && (lat_cnt == 0) && !stuck;
      if (di_read_rdy) di_reg_datao = exp_q[0];
      else             di_reg_datao = $urandom;
      rdata_ready = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_mode = stuck ? (cyc < 2 + TO) : (reads < nwords);
      exp_rsp  = stuck ? (cyc == 2 + TO) : (reads == nwords);
      if (cyc == 1) begin
        chkw("rd_term_reg", 64'(di_term_addr), 64'(t));
        chkw("rd_addr_reg", 64'(di_reg_addr), 64'(a));
      end
      chk1("rd_mode", di_read_mode, exp_mode);
      chk1("wr_mode_in_rd", di_write_mode | di_write, 1'b0);
      chk1("rdata_valid", rdata_valid, di_read_rdy);
      chk1("rd_strobe", di_read, di_read_rdy && rdata_ready);
      chk1("rd_rsp_valid", rsp_valid, exp_rsp);
      if (di_read_req) begin
        chk1("req_while_pending", pending, 1'b0);
        reqs++; pending = 1; lat_cnt = lat;
        exp_q.push_back($urandom);
      end
      if (di_read && exp_q.size() > 0) begin
        chkw("rdata", 64'(rdata), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        pending = 0;
        reads++;
      end
      if (rsp_valid) begin
        done = 1;
        chkw("rd_rsp_status", 64'(rsp_status), stuck ? 64'(16'hFFFE) : 64'(st));
        chk1("rd_rsp_timeout", rsp_timeout, stuck);
        chkw("rd_word_count", 64'(reads), stuck ? 64'(0) : 64'(nwords));
        chkw("rd_req_count", 64'(reqs), stuck ? 64'(1) : 64'(nwords));
        if (nwords == 0) chkw("zero_len_rsp_cycle", 64'(cyc), 64'(1));
      end
    end
    chk1("rd_rsp_within_budget", done, 1'b1);
    if (!aborted) post_idle(t, stuck ? 16'hFFFE : st, stuck);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_term = '0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    di_read_rdy = 1'b0; di_write_rdy = 1'b0; di_reg_datao = '0; di_transfer_status = '0;
    repeat (2) @(posedge ifclk);
    @(negedge ifclk);
    #1;
    chkw("reset_ctrl", 64'({cmd_ready, wdata_ready, rdata_valid, rsp_valid, rsp_timeout, busy,
                            di_read_mode, di_read_req, di_read, di_write_mode, di_write}), 64'(0));
    chkw("reset_regs", 64'({di_term_addr, di_len}), 64'(0));
    chkw("reset_status", 64'({rsp_status, di_reg_addr}), 64'(0));
    reset = 1'b0;
    #1;
    chk1("reset_release_ready", cmd_ready, 1'b1);

    // basic write of three words, always ready
    do_write(16'h0001, 32'h0000_0010, 32'd12, 0, 0, 3);
    // read of two words, responder answers 3 cycles after each request
    do_read(16'h0002, 32'h0000_0020, 32'd8, 3, 0, 1'b0, -1);
    // zero-word commands
    do_write(16'h0003, 32'h0000_0030, 32'd0, 0, 0, 0);
    do_read(16'h0004, 32'h0000_0040, 32'd3, 3, 0, 1'b0, -1);
    // write-ready toggling
    do_write(16'(($urandom)), $urandom, 32'd16, 1, 0, -1);
    // randomized mix
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(16'($urandom), $urandom, 32'($urandom_range(0, 27)), 2, 1, -1);
      else
        do_read(16'($urandom), $urandom, 32'($urandom_range(0, 27)), $urandom_range(1, 4), 1, 1'b0, -1);
    end
`ifdef DI_TIMEOUT_EN
    do_read(16'h0005, 32'h0000_0050, 32'd8, 3, 0, 1'b1, -1);
`endif
    // reset while waiting on the second of four read words, then a fresh command
    do_read(16'h0006, 32'h0000_0060, 32'd16, 2, 0, 1'b0, 1);
    do_write(16'h0007, 32'h0000_0070, 32'd8, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
